// File: rtl/stream_upsizer.sv
// Packs a narrow valid/ready stream into words SCALE lanes wide, lane 0 first.
// A partially filled word is flushed early on s_last_i; m_keep_o marks the filled lanes.
module stream_upsizer #(
    parameter int DW_IN = 8,
    parameter int SCALE = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DW_IN-1:0]       s_data_i,
    input  logic                   s_valid_i,
    input  logic                   s_last_i,
    output logic                   s_ready_o,
    output logic [DW_IN*SCALE-1:0] m_data_o,
    output logic [SCALE-1:0]       m_keep_o,
    output logic                   m_last_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i
);
    localparam int OW = DW_IN * SCALE;
    localparam int CW = $clog2(SCALE);

    logic [OW-1:0]    acc_q, acc_d;
    logic [SCALE-1:0] acc_keep_q, acc_keep_d;
    logic             acc_last_q, acc_last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic [OW-1:0]    out_data_q, out_data_d;
    logic [SCALE-1:0] out_keep_q, out_keep_d;
    logic             out_last_q, out_last_d;
    logic             out_valid_q, out_valid_d;
    logic             rst_r_q;

    logic [OW-1:0]    word;
    logic [SCALE-1:0] word_keep;
    logic             wr, rd, completing;

    // Accumulator with the incoming beat dropped into lane cnt.
    genvar gi;
    generate
        for (gi = 0; gi < SCALE; gi++) begin : g_lane
            assign word[gi*DW_IN +: DW_IN] = (cnt_q == CW'(gi)) ? s_data_i
                                                                : acc_q[gi*DW_IN +: DW_IN];
            assign word_keep[gi] = acc_keep_q[gi] | (cnt_q == CW'(gi));
        end
    endgenerate

    assign s_ready_o  = !pend_q && !rst_r_q && !rst;
    assign wr         = s_valid_i && s_ready_o;
    assign rd         = out_valid_q && m_ready_i;
    assign completing = (cnt_q == CW'(SCALE - 1)) || s_last_i;

    always_comb begin
        acc_d       = acc_q;
        acc_keep_d  = acc_keep_q;
        acc_last_d  = acc_last_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q && !rd;

        if (pend_q && rd) begin
            out_data_d  = acc_q;
            out_keep_d  = acc_keep_q;
            out_last_d  = acc_last_q;
            out_valid_d = 1'b1;
            acc_d       = '0;
            acc_keep_d  = '0;
            acc_last_d  = 1'b0;
            cnt_d       = '0;
            pend_d      = 1'b0;
        end else if (wr) begin
            if (!completing) begin
                acc_d      = word;
                acc_keep_d = word_keep;
                cnt_d      = cnt_q + CW'(1);
            end else if (!out_valid_q || rd) begin
                out_data_d  = word;
                out_keep_d  = word_keep;
                out_last_d  = s_last_i;
                out_valid_d = 1'b1;
                acc_d       = '0;
                acc_keep_d  = '0;
                acc_last_d  = 1'b0;
                cnt_d       = '0;
            end else begin
                // Output still occupied: park the finished word until it drains.
                acc_d      = word;
                acc_keep_d = word_keep;
                acc_last_d = s_last_i;
                cnt_d      = '0;
                pend_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        rst_r_q <= rst;
        if (rst) begin
            acc_q       <= '0;
            acc_keep_q  <= '0;
            acc_last_q  <= 1'b0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            acc_keep_q  <= acc_keep_d;
            acc_last_q  <= acc_last_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign m_data_o  = out_data_q;
    assign m_keep_o  = out_keep_q;
    assign m_last_o  = out_last_q;
    assign m_valid_o = out_valid_q;

endmodule
